// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding, the NOP instruction substituted on an abandoned fetch, and the
// packed command that is presented on the shared memory port.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_e;

  // RV32I canonical NOP (addi x0, x0, 0), fed to the pipeline when a fetch
  // is abandoned so the stage behind it sees a harmless instruction.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam int unsigned CNT_W = 8;

  // Everything the memory port sees besides mem_req; latched as one unit so
  // the fields can never drift relative to each other mid-transaction.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_cmd_t;

  // Instruction fetches are always full-word reads.
  function automatic mem_cmd_t fetch_cmd(input logic [31:0] addr);
    mem_cmd_t c;
    c.we    = 1'b0;
    c.addr  = addr;
    c.wdata = 32'h0;
    c.be    = 4'hF;
    return c;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates the fetch stage and the memory stage onto a single registered
// memory port. Data accesses win over fetches (they belong to the older
// instruction). Each transaction is held stable until mem_ack or until
// WAIT_MAX cycles pass without one, in which case it is abandoned with a
// one-cycle timeout pulse and a safe result (NOP for fetch, 0 for load).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr/if_rdata    fetch request, address, registered fetched word
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_be/dm_rdata    load/store request and registered load data
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be           registered shared memory port request
//   mem_ack/mem_rdata          memory completion and read data
//   stalled                    combinational stall to the hazard unit
//   timeout                    one-cycle pulse when a transaction is abandoned
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stalled,
  output logic        timeout
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

  arb_state_e       state_q,    state_d;
  mem_cmd_t         cmd_q,      cmd_d;
  logic             mem_req_q,  mem_req_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      dm_rdata_q, dm_rdata_d;
  logic             d_done_q,   d_done_d;
  logic             i_done_q,   i_done_d;
  logic             timeout_q,  timeout_d;

  logic             d_pend;
  logic             i_pend;
  logic [CNT_W-1:0] cnt_inc;

  // A requester is pending until its done flag covers the current request.
  assign d_pend  = dm_req & ~d_done_q;
  assign i_pend  = if_req & ~i_done_q;
  assign stalled = d_pend | i_pend;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // can leave it unassigned and infer a latch.
    state_d    = state_q;
    cmd_d      = cmd_q;
    mem_req_d  = mem_req_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    timeout_d  = 1'b0;
    // The pipeline advances on any edge where stalled is low, retiring both
    // done flags. A completion below overrides this, so a flushed request
    // still records its done flag and it retires on the following edge.
    d_done_d   = stalled ? d_done_q : 1'b0;
    i_done_d   = stalled ? i_done_q : 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_pend) begin
          state_d   = DATA;
          mem_req_d = 1'b1;
          cmd_d     = '{we: dm_we, addr: dm_addr, wdata: dm_wdata, be: dm_be};
          cnt_d     = '0;
        end else if (i_pend) begin
          state_d   = FETCH;
          mem_req_d = 1'b1;
          cmd_d     = fetch_cmd(if_addr);
          cnt_d     = '0;
        end
      end

      DATA: begin
        if (mem_ack) begin
          d_done_d = 1'b1;
          if (!cmd_q.we) dm_rdata_d = mem_rdata;
          if (i_pend) begin
            // Chain straight into the fetch; mem_req never drops.
            state_d = FETCH;
            cmd_d   = fetch_cmd(if_addr);
            cnt_d   = '0;
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end else if (cnt_inc == WAIT_LIM) begin
          timeout_d = 1'b1;
          d_done_d  = 1'b1;
          // A store leaves no load result, so dm_rdata is only zeroed for loads.
          if (!cmd_q.we) dm_rdata_d = 32'h0;
          state_d   = IDLE;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      FETCH: begin
        if (mem_ack) begin
          i_done_d   = 1'b1;
          if_rdata_d = mem_rdata;
          state_d    = IDLE;
          mem_req_d  = 1'b0;
        end else if (cnt_inc == WAIT_LIM) begin
          timeout_d  = 1'b1;
          i_done_d   = 1'b1;
          if_rdata_d = NOP_INSN;
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      mem_req_q  <= 1'b0;
      cnt_q      <= '0;
      if_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
      d_done_q   <= 1'b0;
      i_done_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      mem_req_q  <= mem_req_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      d_done_q   <= d_done_d;
      i_done_q   <= i_done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_be    = cmd_q.be;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign timeout   = timeout_q;

endmodule
